traceback_unit: RTL and testbench

Survivor-memory and traceback stage of the Viterbi decoder, directly downstream of the ACS unit and driven by the top-level controller's `en_mem` and `en_trbk` enables. During the memory phase it stores one survivor-decision vector per trellis step. On `en_trbk` it traces back from a supplied end state, then emits the decoded bits serially in original message order, with a parallel copy also provided.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/traceback_unit_if.sv | 25 ++
 rtl/survivor_ram.sv | 24 ++
 rtl/traceback_unit.sv | 115 +++++++++++
 tb/tb_traceback_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and the traceback FSM state type.
package viterbi_pkg;

    localparam int unsigned SW         = 2;
    localparam int unsigned NUM_STATES = 2 ** SW;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned AW         = $clog2(DEPTH);
    // One extra bit so a full memory (DEPTH steps) is representable.
    localparam int unsigned PW         = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StTrace,
        StEmit,
        StDone
    } tb_state_e;

endpackage

// File: rtl/traceback_unit_if.sv
// Controller/ACS side handshake of the traceback unit.
interface traceback_unit_if;
    import viterbi_pkg::*;

    logic                  en_mem;
    logic                  en_trbk;
    logic [NUM_STATES-1:0] surv_in;
    logic [SW-1:0]         end_state;
    logic                  dec_bit;
    logic                  dec_valid;
    logic [DEPTH-1:0]      dec_word;
    logic [PW-1:0]         n_bits;
    logic                  done;

    modport master (
        output en_mem, en_trbk, surv_in, end_state,
        input  dec_bit, dec_valid, dec_word, n_bits, done
    );

    modport slave (
        input  en_mem, en_trbk, surv_in, end_state,
        output dec_bit, dec_valid, dec_word, n_bits, done
    );

endinterface

// File: rtl/survivor_ram.sv
// DEPTH x NUM_STATES survivor register file: sync write, combinational read.
module survivor_ram
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [NUM_STATES-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [NUM_STATES-1:0] rdata
);

    logic [NUM_STATES-1:0] mem [DEPTH];

    // Contents need no reset; only written rows are ever traced.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/traceback_unit.sv
// Survivor storage, traceback and in-order serial emission of decoded bits.
module traceback_unit
    import viterbi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    traceback_unit_if.slave  bus
);

    tb_state_e             state_q;
    logic [PW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [PW-1:0]         eptr_q;
    logic [SW-1:0]         cur_q;
    logic [DEPTH-1:0]      bitbuf_q;
    logic [PW-1:0]         n_bits_q;
    logic                  dec_bit_q;
    logic                  dec_valid_q;
    logic                  done_q;

    logic                  we;
    logic [NUM_STATES-1:0] rdata;
    logic                  d;

    // Traceback enable wins over a same-cycle write; writes past DEPTH are dropped.
    always_comb begin
        we = bus.en_mem && !bus.en_trbk &&
             ((state_q == StIdle) || ((state_q == StStore) && (wptr_q < PW'(DEPTH))));
    end

    assign d = rdata[cur_q];

    survivor_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (bus.surv_in),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    // Single FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            eptr_q      <= '0;
            cur_q       <= '0;
            bitbuf_q    <= '0;
            n_bits_q    <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StStore: begin
                    if (bus.en_trbk) begin
                        state_q  <= StTrace;
                        cur_q    <= bus.end_state;
                        rptr_q   <= AW'(wptr_q - PW'(1));
                        n_bits_q <= wptr_q;
                    end else if (bus.en_mem) begin
                        state_q <= StStore;
                        if (wptr_q < PW'(DEPTH)) begin
                            wptr_q <= wptr_q + PW'(1);
                        end
                    end
                end
                StTrace: begin
                    if (n_bits_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        bitbuf_q[rptr_q] <= cur_q[SW-1];
                        cur_q            <= {cur_q[SW-2:0], d};
                        if (rptr_q == '0) begin
                            // Step 0's bit goes straight out so emission starts next cycle.
                            state_q     <= StEmit;
                            dec_valid_q <= 1'b1;
                            dec_bit_q   <= cur_q[SW-1];
                            eptr_q      <= PW'(1);
                        end else begin
                            rptr_q <= rptr_q - AW'(1);
                        end
                    end
                end
                StEmit: begin
                    if (eptr_q == n_bits_q) begin
                        // One idle cycle separates the last valid bit from done.
                        state_q     <= StDone;
                        dec_valid_q <= 1'b0;
                        dec_bit_q   <= 1'b0;
                    end else begin
                        dec_bit_q <= bitbuf_q[eptr_q[AW-1:0]];
                        eptr_q    <= eptr_q + PW'(1);
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.dec_bit   = dec_bit_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_word  = bitbuf_q;
    assign bus.n_bits    = n_bits_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: table-driven runs plus a mid-emit reset.
module tb_traceback_unit;
    import viterbi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    traceback_unit_if tif ();

    traceback_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] surv_flat;   // vector i at [4*i +: 4]
        int          nwr;
        logic        mem_at_trig;
        logic        mem_hold;
        logic [3:0]  trig_surv;
        logic [1:0]  end_st;
        int          exp_n;
        logic [7:0]  exp_word;
    } tv_t;

    tv_t cases [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst           = 1'b0;
        tif.en_mem    = 1'b0;
        tif.en_trbk   = 1'b0;
        tif.surv_in   = '0;
        tif.end_state = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Writes the vectors, then raises en_trbk; returns just after edge E.
    task automatic load(input tv_t tv);
        for (int i = 0; i < tv.nwr; i++) begin
            @(negedge clk);
            tif.en_mem  = 1'b1;
            tif.en_trbk = 1'b0;
            tif.surv_in = tv.surv_flat[4*i +: 4];
        end
        @(negedge clk);
        tif.en_mem    = tv.mem_at_trig;
        tif.en_trbk   = 1'b1;
        tif.surv_in   = tv.trig_surv;
        tif.end_state = tv.end_st;
        @(posedge clk);
        #1;
        tif.en_mem = tv.mem_hold;
    endtask

    task automatic run_case(input tv_t tv, input bit do_reset);
        int         cnt = 0;
        int         bad_window = 0;
        int         overlap = 0;
        int         first_done = -1;
        int         exp_done;
        int         ncyc;
        logic [7:0] ser = '0;
        if (do_reset) reset_dut();
        load(tv);
        exp_done = (tv.exp_n == 0) ? 1 : 2 * tv.exp_n + 1;
        ncyc     = 2 * tv.exp_n + 6;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            if (tif.dec_valid) begin
                if (cnt < 8) ser[cnt] = tif.dec_bit;
                cnt++;
                if (cyc < tv.exp_n || cyc > 2 * tv.exp_n - 1) bad_window++;
                if (tif.done) overlap++;
            end
            if (tif.done && first_done < 0) first_done = cyc;
        end
        chk({tv.name, " valid_count"}, cnt, tv.exp_n);
        chk({tv.name, " serial_bits"}, {24'h0, ser}, {24'h0, tv.exp_word});
        chk({tv.name, " valid_window"}, bad_window, 0);
        chk({tv.name, " valid_done_overlap"}, overlap, 0);
        chk({tv.name, " done_cycle"}, first_done, exp_done);
        chk({tv.name, " dec_word"}, {24'h0, tif.dec_word}, {24'h0, tv.exp_word});
        chk({tv.name, " n_bits"}, {28'h0, tif.n_bits}, tv.exp_n);
        chk({tv.name, " done_sticky"}, {31'h0, tif.done}, 1);
        tif.en_mem  = 1'b0;
        tif.en_trbk = 1'b0;
    endtask

    initial begin
        int cnt;
        // Known path u=1,0,1,1,0,1,0,0 from state 0 ends in state 0.
        cases[0] = '{"all_zero", 40'h0, 8, 1'b0, 1'b1, 4'h0, 2'd0, 8, 8'h00};
        cases[1] = '{"known_path", 40'h00395A76DB, 8, 1'b0, 1'b1, 4'hF, 2'd0, 8, 8'h2D};
        cases[2] = '{"overflow", 40'hFF395A76DB, 10, 1'b0, 1'b1, 4'hF, 2'd0, 8, 8'h2D};
        // u=1,1,0 from state 0 ends in state 1.
        cases[3] = '{"short_simul", 40'h0000000273, 3, 1'b1, 1'b1, 4'hF, 2'd1, 3, 8'h03};
        cases[4] = '{"empty_hold", 40'h0, 0, 1'b0, 1'b1, 4'hF, 2'd0, 0, 8'h00};

        reset_dut();
        rst = 1'b0;
        #1;
        chk("reset dec_bit", {31'h0, tif.dec_bit}, 0);
        chk("reset dec_valid", {31'h0, tif.dec_valid}, 0);
        chk("reset done", {31'h0, tif.done}, 0);
        chk("reset dec_word", {24'h0, tif.dec_word}, 0);
        chk("reset n_bits", {28'h0, tif.n_bits}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            run_case(cases[k], 1'b1);
        end

        // Empty run held in DONE with en_mem high: nothing may move.
        tif.en_mem = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold done", {31'h0, tif.done}, 1);
        chk("done_hold n_bits", {28'h0, tif.n_bits}, 0);
        chk("done_hold dec_valid", {31'h0, tif.dec_valid}, 0);
        tif.en_mem = 1'b0;

        // Reset in the middle of emission, after three bits.
        reset_dut();
        load(cases[1]);
        cnt = 0;
        for (int cyc = 0; cyc < 40 && cnt < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (tif.dec_valid) cnt++;
        end
        chk("abort reached_emit", cnt, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("abort dec_valid", {31'h0, tif.dec_valid}, 0);
        chk("abort dec_bit", {31'h0, tif.dec_bit}, 0);
        chk("abort done", {31'h0, tif.done}, 0);
        chk("abort dec_word", {24'h0, tif.dec_word}, 0);
        chk("abort n_bits", {28'h0, tif.n_bits}, 0);
        tif.en_mem  = 1'b0;
        tif.en_trbk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no_partial_valid", {31'h0, tif.dec_valid}, 0);
        chk("abort no_partial_done", {31'h0, tif.done}, 0);
        run_case(cases[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
